// File: rtl/boreal_ledger_pkg.sv
// Shared definitions for the boreal ledger: register word offsets, CTRL bit
// positions, FSM state type and the digest mixing function.
package boreal_ledger_pkg;

  // Word offsets as seen on ledger_addr[7:2]
  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_APPEND  = 6'h01;
  localparam logic [5:0] OFF_COUNT   = 6'h02;
  localparam logic [5:0] OFF_DROPS   = 6'h03;
  localparam logic [5:0] OFF_RD_IDX  = 6'h04;
  localparam logic [5:0] OFF_RD_DATA = 6'h05;
  localparam logic [5:0] OFF_DIGEST  = 6'h06;

  localparam int CTRL_SEAL_BIT   = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int CTRL_SEALED_POS = 10;
  localparam int CTRL_FULL_POS   = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESP,
    ST_HOLD
  } ledger_state_t;

  function automatic logic [31:0] digest_mix(input logic [31:0] digest, input logic [31:0] word);
    return {digest[26:0], digest[31:27]} ^ word;
  endfunction

endpackage

// File: rtl/boreal_ledger_mem.sv
// Entry storage for the boreal ledger: single-port synchronous RAM with a
// write enable and a registered (1-cycle) read.
module boreal_ledger_mem
  import boreal_ledger_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      ram[addr] <= wdata;
    end
    rdata <= ram[addr];
  end

endmodule

// File: rtl/boreal_ledger.sv
// Append-only 32-bit ledger behind a simple select/ack slave port.
// Optional running digest enabled with `define BOREAL_LEDGER_DIGEST_EN.
module boreal_ledger
  import boreal_ledger_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DROP_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ledger_sel,
  input  logic        ledger_wr,
  input  logic [31:0] ledger_addr,
  input  logic [31:0] ledger_wdata,
  output logic [31:0] ledger_rdata,
  output logic        ledger_ack,
  output logic        ledger_full,
  output logic        ledger_sealed
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  ledger_state_t     state_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DROP_W-1:0] drops_reg;
  logic [IDX_W-1:0]  rd_idx_reg;
  logic              sealed_reg;
  logic              ack_reg;
  logic [31:0]       rdata_reg;

  logic [5:0]        offset;
  logic              full;
  logic              start;
  logic              wr_start;
  logic              append_ok;
  logic              append_drop;
  logic              ctrl_clear;
  logic              ctrl_seal;
  logic              idx_write;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_addr;
  logic [31:0]       mem_rdata;
  logic [31:0]       digest_val;
  logic [31:0]       ctrl_word;
  logic [31:0]       reg_rdata;
  logic              unused_addr_bits;

  assign offset           = ledger_addr[7:2];
  assign unused_addr_bits = ^{ledger_addr[31:8], ledger_addr[1:0]};
  assign full             = (count_reg == CNT_MAX);

  // Side effects only ever fire on the IDLE sample cycle.
  assign start       = (state_reg == ST_IDLE) && ledger_sel;
  assign wr_start    = start && ledger_wr;
  assign append_ok   = wr_start && (offset == OFF_APPEND) && !full && !sealed_reg;
  assign append_drop = wr_start && (offset == OFF_APPEND) && (full || sealed_reg);
  assign ctrl_clear  = wr_start && (offset == OFF_CTRL) && ledger_wdata[CTRL_CLEAR_BIT] && !sealed_reg;
  assign ctrl_seal   = wr_start && (offset == OFF_CTRL) && ledger_wdata[CTRL_SEAL_BIT];
  assign idx_write   = wr_start && (offset == OFF_RD_IDX);

  // Gating with rst_n keeps an aborted access from landing in the RAM.
  assign mem_we   = append_ok && rst_n;
  assign mem_addr = ledger_wr ? count_reg[IDX_W-1:0] : rd_idx_reg;

  boreal_ledger_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (ledger_wdata),
    .rdata (mem_rdata)
  );

`ifdef BOREAL_LEDGER_DIGEST_EN
  logic [31:0] digest_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || ctrl_clear) begin
      digest_reg <= '0;
    end else if (append_ok) begin
      digest_reg <= digest_mix(digest_reg, ledger_wdata);
    end
  end

  assign digest_val = digest_reg;
`else
  assign digest_val = '0;
`endif

  always_comb begin
    ctrl_word                  = '0;
    ctrl_word[9:0]             = 10'(count_reg);
    ctrl_word[CTRL_SEALED_POS] = sealed_reg;
    ctrl_word[CTRL_FULL_POS]   = full;
  end

  always_comb begin
    reg_rdata = '0;
    case (offset)
      OFF_CTRL:   reg_rdata = ctrl_word;
      OFF_COUNT:  reg_rdata = 32'(count_reg);
      OFF_DROPS:  reg_rdata = 32'(drops_reg);
      OFF_RD_IDX: reg_rdata = 32'(rd_idx_reg);
      OFF_DIGEST: reg_rdata = digest_val;
      default:    reg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      ack_reg    <= 1'b0;
      rdata_reg  <= '0;
      count_reg  <= '0;
      drops_reg  <= '0;
      rd_idx_reg <= '0;
      sealed_reg <= 1'b0;
    end else begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;

      case (state_reg)
        ST_IDLE: begin
          if (ledger_sel) begin
            if (!ledger_wr && (offset == OFF_RD_DATA)) begin
              state_reg <= ST_READ;
            end else begin
              state_reg <= ST_RESP;
              ack_reg   <= 1'b1;
              rdata_reg <= ledger_wr ? 32'd0 : reg_rdata;
            end
          end
        end
        ST_READ: begin
          state_reg <= ST_RESP;
          ack_reg   <= 1'b1;
          rdata_reg <= ({1'b0, rd_idx_reg} < count_reg) ? mem_rdata : 32'd0;
        end
        ST_RESP: begin
          state_reg <= ledger_sel ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          if (!ledger_sel) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Clear is evaluated against the pre-write seal, so 0x3 clears then seals.
      if (ctrl_clear) begin
        count_reg <= '0;
        drops_reg <= '0;
      end else if (append_ok) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (append_drop && (drops_reg != DROP_MAX)) begin
        drops_reg <= drops_reg + DROP_W'(1);
      end

      if (ctrl_seal) begin
        sealed_reg <= 1'b1;
      end

      if (idx_write) begin
        rd_idx_reg <= ledger_wdata[IDX_W-1:0];
      end
    end
  end

  assign ledger_rdata  = rdata_reg;
  assign ledger_ack    = ack_reg;
  assign ledger_full   = full;
  assign ledger_sealed = sealed_reg;

endmodule

// File: tb/tb_boreal_ledger.sv
// Self-checking bench for boreal_ledger (DEPTH=4, DROP_W=3) against a
// queue-based reference model; digest expectations follow BOREAL_LEDGER_DIGEST_EN.
module tb_boreal_ledger;

  localparam int DEPTH    = 4;
  localparam int DROP_W   = 3;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  localparam logic [31:0] A_CTRL    = 32'h00;
  localparam logic [31:0] A_APPEND  = 32'h04;
  localparam logic [31:0] A_COUNT   = 32'h08;
  localparam logic [31:0] A_DROPS   = 32'h0C;
  localparam logic [31:0] A_RD_IDX  = 32'h10;
  localparam logic [31:0] A_RD_DATA = 32'h14;
  localparam logic [31:0] A_DIGEST  = 32'h18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b_sel = 1'b0;
  logic        b_wr = 1'b0;
  logic [31:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_full;
  logic        d_sealed;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  logic [31:0] m_entries[$];
  int          m_drops;
  logic        m_sealed;
  int          m_rd_idx;
  logic [31:0] m_digest;

  always #5 clk = ~clk;

  boreal_ledger #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ledger_sel    (b_sel),
    .ledger_wr     (b_wr),
    .ledger_addr   (b_addr),
    .ledger_wdata  (b_wdata),
    .ledger_rdata  (d_rdata),
    .ledger_ack    (d_ack),
    .ledger_full   (d_full),
    .ledger_sealed (d_sealed)
  );

  function automatic void model_reset();
    m_entries.delete();
    m_drops  = 0;
    m_sealed = 1'b0;
    m_rd_idx = 0;
    m_digest = '0;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] wd);
    int off;
    off = int'(addr[7:2]);
    if (off == 1) begin
      if (m_entries.size() < DEPTH && !m_sealed) begin
        m_entries.push_back(wd);
        m_digest = ((m_digest << 5) | (m_digest >> 27)) ^ wd;
      end else if (m_drops < DROP_MAX) begin
        m_drops = m_drops + 1;
      end
    end else if (off == 0) begin
      if (wd[1] && !m_sealed) begin
        m_entries.delete();
        m_drops  = 0;
        m_digest = '0;
      end
      if (wd[0]) m_sealed = 1'b1;
    end else if (off == 4) begin
      m_rd_idx = int'(wd[9:0]) % DEPTH;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int off;
    logic [31:0] r;
    off = int'(addr[7:2]);
    r = '0;
    case (off)
      0: r = {20'd0, (m_entries.size() == DEPTH), m_sealed, 10'(m_entries.size())};
      2: r = 32'(m_entries.size());
      3: r = 32'(m_drops);
      4: r = 32'(m_rd_idx);
      5: r = (m_rd_idx < m_entries.size()) ? m_entries[m_rd_idx] : 32'd0;
`ifdef BOREAL_LEDGER_DIGEST_EN
      6: r = m_digest;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // One bus transaction. lat = cycles from sel sample to ack, -1 on timeout,
  // -2 if ack lasted more than one cycle, -3 if rdata was nonzero after ack.
  task automatic bus_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat);
    b_sel = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wd;
    lat = -1;
    rd = '0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (d_ack) begin
        lat = n;
        rd = d_rdata;
        break;
      end
    end
    b_sel = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    @(posedge clk); #1;
    if (d_ack) lat = -2;
    else if (d_rdata !== 32'd0) lat = -3;
    $display("txn wr=%0b addr=%h wdata=%h rdata=%h lat=%0d", wr, addr, wd, rd, lat);
  endtask

  task automatic wr_op(input logic [31:0] addr, input logic [31:0] wd, output int lat);
    logic [31:0] rd;
    bus_access(1'b1, addr, wd, rd, lat);
    model_write(addr, wd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    do_reset();
    total_cnt++;
    if (d_ack !== 1'b0 || d_rdata !== 32'd0 || d_full !== 1'b0 || d_sealed !== 1'b0)
      $display("FAIL reset_outputs: ack=%b rdata=%h full=%b sealed=%b, want all 0", d_ack, d_rdata, d_full, d_sealed);
    else pass_cnt++;
    bus_access(1'b0, A_COUNT, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd0 || lat != 1) $display("FAIL reset_count: got %h lat %0d, want 0 lat 1", rd, lat);
    else pass_cnt++;
    bus_access(1'b0, A_CTRL, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd0 || lat != 1) $display("FAIL reset_ctrl: got %h lat %0d, want 0 lat 1", rd, lat);
    else pass_cnt++;
    bus_access(1'b0, A_DROPS, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd0 || lat != 1) $display("FAIL reset_drops: got %h lat %0d, want 0 lat 1", rd, lat);
    else pass_cnt++;
    bus_access(1'b0, A_DIGEST, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd0 || lat != 1) $display("FAIL reset_digest: got %h lat %0d, want 0 lat 1", rd, lat);
    else pass_cnt++;
  endtask

  task automatic test_append_read();
    logic [31:0] rd;
    int lat;
    do_reset();
    wr_op(A_APPEND, 32'h1111_1111, lat);
    total_cnt++;
    if (lat != 1) $display("FAIL append_latency: got %0d, want 1", lat);
    else pass_cnt++;
    wr_op(A_APPEND, 32'h2222_2222, lat);
    wr_op(A_RD_IDX, 32'h1, lat);
    bus_access(1'b0, A_RD_IDX, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd1 || lat != 1) $display("FAIL rd_idx_readback: got %h lat %0d, want 1 lat 1", rd, lat);
    else pass_cnt++;
    bus_access(1'b0, A_RD_DATA, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'h2222_2222 || lat != 2) $display("FAIL rd_data_idx1: got %h lat %0d, want 22222222 lat 2", rd, lat);
    else pass_cnt++;
    wr_op(A_RD_IDX, 32'h2, lat);
    bus_access(1'b0, A_RD_DATA, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd0 || lat != 2) $display("FAIL rd_data_past_count: got %h lat %0d, want 0 lat 2", rd, lat);
    else pass_cnt++;
  endtask

  task automatic test_full_drops();
    logic [31:0] rd;
    logic [31:0] vals[6];
    int lat;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vals[i] = $urandom;
      wr_op(A_APPEND, vals[i], lat);
    end
    bus_access(1'b0, A_COUNT, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd4) $display("FAIL full_count: got %h, want 4", rd);
    else pass_cnt++;
    bus_access(1'b0, A_DROPS, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd2) $display("FAIL full_drops: got %h, want 2", rd);
    else pass_cnt++;
    total_cnt++;
    if (d_full !== 1'b1) $display("FAIL full_flag: got %b, want 1", d_full);
    else pass_cnt++;
    wr_op(A_RD_IDX, 32'h3, lat);
    bus_access(1'b0, A_RD_DATA, '0, rd, lat);
    total_cnt++;
    if (rd !== vals[3] || lat != 2) $display("FAIL full_entry3: got %h lat %0d, want %h lat 2", rd, lat, vals[3]);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) wr_op(A_APPEND, $urandom, lat);
    bus_access(1'b0, A_DROPS, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'(DROP_MAX)) $display("FAIL drops_saturate: got %h, want %h", rd, DROP_MAX);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    int lat;
    int op;
    int off;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 6) begin
        if (op <= 3)      off = 1;
        else if (op == 4) off = 0;
        else if (op == 5) off = 4;
        else              off = $urandom_range(7, 63);
        addr = ($urandom & 32'hFFFF_FF00) | 32'(off << 2) | ($urandom & 32'h3);
        wd = (off == 0) ? 32'h2 : $urandom;
        wr_op(addr, wd, lat);
        total_cnt++;
        if (lat != 1) $display("FAIL rand_write_%0d: lat %0d, want 1", i, lat);
        else pass_cnt++;
      end else begin
        off = $urandom_range(0, 15);
        addr = ($urandom & 32'hFFFF_FF00) | 32'(off << 2) | ($urandom & 32'h3);
        exp = model_read(addr);
        bus_access(1'b0, addr, '0, rd, lat);
        total_cnt++;
        if (rd !== exp || lat != ((off == 5) ? 2 : 1))
          $display("FAIL rand_read_%0d: addr %h got %h lat %0d, want %h lat %0d",
                   i, addr, rd, lat, exp, (off == 5) ? 2 : 1);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_seal();
    logic [31:0] rd;
    int lat;
    do_reset();
    wr_op(A_APPEND, $urandom, lat);
    wr_op(A_APPEND, $urandom, lat);
    wr_op(A_CTRL, 32'h1, lat);
    total_cnt++;
    if (d_sealed !== 1'b1) $display("FAIL seal_flag: got %b, want 1", d_sealed);
    else pass_cnt++;
    wr_op(A_APPEND, 32'hDEAD_BEEF, lat);
    bus_access(1'b0, A_COUNT, '0, rd, lat);
    total_cnt++;
    if (rd !== model_read(A_COUNT)) $display("FAIL sealed_count: got %h, want %h", rd, model_read(A_COUNT));
    else pass_cnt++;
    bus_access(1'b0, A_DROPS, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd1) $display("FAIL sealed_drops: got %h, want 1", rd);
    else pass_cnt++;
    wr_op(A_CTRL, 32'h2, lat);
    bus_access(1'b0, A_CTRL, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'h0000_0402) $display("FAIL sealed_no_clear: got %h, want 00000402", rd);
    else pass_cnt++;
    do_reset();
    wr_op(A_APPEND, $urandom, lat);
    wr_op(A_CTRL, 32'h3, lat);
    bus_access(1'b0, A_CTRL, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'h0000_0400) $display("FAIL clear_then_seal: got %h, want 00000400", rd);
    else pass_cnt++;
  endtask

  task automatic test_digest();
    logic [31:0] rd;
    logic [31:0] exp;
    int lat;
    do_reset();
    wr_op(A_APPEND, 32'h1, lat);
    wr_op(A_APPEND, 32'h2, lat);
`ifdef BOREAL_LEDGER_DIGEST_EN
    exp = 32'h0000_0022;
`else
    exp = 32'h0;
`endif
    bus_access(1'b0, A_DIGEST, '0, rd, lat);
    total_cnt++;
    if (rd !== exp || lat != 1) $display("FAIL digest: got %h lat %0d, want %h lat 1", rd, lat, exp);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    logic [31:0] rd;
    logic [31:0] wd;
    int lat;
    int acks;
    do_reset();
    wd = $urandom;
    acks = 0;
    b_sel = 1'b1; b_wr = 1'b1; b_addr = A_APPEND; b_wdata = wd;
    repeat (5) begin
      @(posedge clk); #1;
      if (d_ack) acks++;
    end
    b_sel = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) begin
      @(posedge clk); #1;
      if (d_ack) acks++;
    end
    model_write(A_APPEND, wd);
    $display("txn held-sel append wdata=%h acks=%0d", wd, acks);
    total_cnt++;
    if (acks != 1) $display("FAIL hold_single_ack: got %0d acks, want 1", acks);
    else pass_cnt++;
    bus_access(1'b0, A_COUNT, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd1) $display("FAIL hold_count: got %h, want 1", rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rd;
    int lat;
    int acks;
    do_reset();
    wr_op(A_APPEND, $urandom, lat);
    acks = 0;
    b_sel = 1'b1; b_wr = 1'b0; b_addr = A_RD_DATA;
    @(posedge clk); #1;
    if (d_ack) acks++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    if (d_ack) acks++;
    b_sel = 1'b0; b_addr = '0;
    rst_n = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      if (d_ack) acks++;
    end
    $display("txn rd_data aborted by reset acks=%0d", acks);
    total_cnt++;
    if (acks != 0) $display("FAIL reset_abort_ack: got %0d acks, want 0", acks);
    else pass_cnt++;
    bus_access(1'b0, A_COUNT, '0, rd, lat);
    total_cnt++;
    if (rd !== 32'd0 || lat != 1) $display("FAIL reset_abort_idle: got %h lat %0d, want 0 lat 1", rd, lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_append_read();
    test_full_drops();
    test_random();
    test_seal();
    test_digest();
    test_hold();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
